lmb_bram_if_ctrl: RTL and testbench

- LMB slave controller directly upstream of the dual-port data/instruction BRAM block; converts one LMB slave port into one BRAM port (A or B).
- Decodes the LMB address window, drives BRAM enable, byte write-enables, address and write data.
- Returns read data and generates the Sl_Ready/Sl_Wait handshake, with an optional programmable wait-state insertion.

---
 rtl/lmb_pkg.sv | 24 ++
 rtl/lmb_addr_decode.sv | 18 +
 rtl/lmb_bram_if_ctrl.sv | 127 ++++++++++++
 tb/tb_lmb_bram_if_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmb_pkg.sv
// Shared LMB slave definitions: bus widths, controller FSM encoding and the
// address-window mask helper used by every LMB peripheral decoder.
package lmb_pkg;

  localparam int LMB_AWIDTH = 32;
  localparam int LMB_DWIDTH = 32;
  localparam int LMB_NUM_WE = LMB_DWIDTH / 8;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lmb_state_e;

  // Window is power-of-2 sized and aligned, so high - base is the offset mask.
  function automatic logic [LMB_AWIDTH-1:0] addr_mask(
    input logic [LMB_AWIDTH-1:0] base,
    input logic [LMB_AWIDTH-1:0] high
  );
    return high - base;
  endfunction

endpackage

// File: rtl/lmb_addr_decode.sv
// Combinational LMB window decode: hit when the address, with the window
// offset bits cleared, equals the base address. Zero latency, no state.
module lmb_addr_decode
  import lmb_pkg::*;
#(
  parameter int                AW         = LMB_AWIDTH,
  parameter logic [AW-1:0]     C_BASEADDR = '0,
  parameter logic [AW-1:0]     C_HIGHADDR = AW'(32'h0000_7FFF)
) (
  input  logic [AW-1:0] addr,
  output logic          hit
);

  localparam logic [AW-1:0] MASK = AW'(addr_mask(C_BASEADDR, C_HIGHADDR));

  assign hit = ((addr & ~MASK) == C_BASEADDR);

endmodule

// File: rtl/lmb_bram_if_ctrl.sv
// LMB slave to single BRAM port bridge; Sl_Ready 1 + C_WAIT_STATES cycles after the
// strobe, one access in flight, strobes outside IDLE are ignored (no backpressure path).
module lmb_bram_if_ctrl
  import lmb_pkg::*;
#(
  parameter int                      C_LMB_AWIDTH  = LMB_AWIDTH,
  parameter int                      C_LMB_DWIDTH  = LMB_DWIDTH,
  parameter int                      C_NUM_WE      = LMB_NUM_WE,
  parameter logic [C_LMB_AWIDTH-1:0] C_BASEADDR    = '0,
  parameter logic [C_LMB_AWIDTH-1:0] C_HIGHADDR    = C_LMB_AWIDTH'(32'h0000_7FFF),
  parameter int                      C_WAIT_STATES = 0
) (
  // LMB numbers bits MSB-first; here vectors are [N-1:0], so LMB bit 0 is the
  // top bit and LMB_BE[0] (bits 0:7) is LMB_BE[C_NUM_WE-1] (the top byte).
  input  logic                    LMB_Clk,
  input  logic                    LMB_Rst,
  input  logic [C_LMB_AWIDTH-1:0] LMB_ABus,
  input  logic [C_LMB_DWIDTH-1:0] LMB_WriteDBus,
  input  logic                    LMB_AddrStrobe,
  input  logic                    LMB_ReadStrobe,
  input  logic                    LMB_WriteStrobe,
  input  logic [C_NUM_WE-1:0]     LMB_BE,
  output logic [C_LMB_DWIDTH-1:0] Sl_DBus,
  output logic                    Sl_Ready,
  output logic                    Sl_Wait,
  output logic                    Sl_UE,
  output logic                    Sl_CE,
  output logic                    BRAM_Rst_A,
  output logic                    BRAM_Clk_A,
  output logic                    BRAM_EN_A,
  output logic [C_NUM_WE-1:0]     BRAM_WEN_A,
  output logic [C_LMB_AWIDTH-1:0] BRAM_Addr_A,
  input  logic [C_LMB_DWIDTH-1:0] BRAM_Din_A,
  output logic [C_LMB_DWIDTH-1:0] BRAM_Dout_A
);

  localparam logic [CNT_W-1:0] WS_LOAD =
    (C_WAIT_STATES > 0) ? CNT_W'(C_WAIT_STATES - 1) : '0;

  lmb_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rd_flag_q, rd_flag_d;
  logic                    cap_q, cap_d;
  logic [C_LMB_DWIDTH-1:0] rdata_q, rdata_d;
  logic [C_LMB_DWIDTH-1:0] rdata_sel;
  logic                    hit;
  logic                    accept;

  lmb_addr_decode #(
    .AW         (C_LMB_AWIDTH),
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_decode (
    .addr (LMB_ABus),
    .hit  (hit)
  );

  // Reset is gated in so the BRAM is never enabled while the slave is held in reset.
  assign accept = LMB_AddrStrobe & hit & (state_q == ST_IDLE) & ~LMB_Rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_flag_d = rd_flag_q;
    cap_d     = accept;
    rdata_d   = rdata_q;
    // BRAM output is valid exactly one cycle after its enable.
    if (cap_q) begin
      rdata_d = BRAM_Din_A;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_flag_d = LMB_ReadStrobe & ~LMB_WriteStrobe;
          if (C_WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge LMB_Clk) begin
    if (LMB_Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_flag_q <= 1'b0;
      cap_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_flag_q <= rd_flag_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
    end
  end

  // With no wait states the Ready cycle is the BRAM data cycle, so bypass the register.
  assign rdata_sel = (C_WAIT_STATES == 0) ? BRAM_Din_A : rdata_q;

  assign Sl_Ready    = (state_q == ST_RESP);
  assign Sl_Wait     = (state_q == ST_WAIT);
  assign Sl_DBus     = (Sl_Ready && rd_flag_q) ? rdata_sel : '0;
  assign Sl_UE       = 1'b0;
  assign Sl_CE       = 1'b0;

  assign BRAM_Rst_A  = LMB_Rst;
  assign BRAM_Clk_A  = LMB_Clk;
  assign BRAM_EN_A   = accept;
  assign BRAM_WEN_A  = (accept && LMB_WriteStrobe) ? LMB_BE : '0;
  assign BRAM_Addr_A = LMB_ABus;
  assign BRAM_Dout_A = LMB_WriteDBus;

endmodule

// File: tb/tb_lmb_bram_if_ctrl.sv
// Bench for lmb_bram_if_ctrl: one instance with no wait states, one with three,
// each backed by a small byte-writable BRAM model with a one-cycle read.
module tb_lmb_bram_if_ctrl;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic        exp_en;
    logic [3:0]  exp_wen;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    int          d;
    int          start;
    int          due;
    logic [31:0] data;
  } sb_t;

  logic        clk;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en;
  logic        mem_clr;
  sb_t         sbq[$];

  logic        rst     [2];
  logic [31:0] abus    [2];
  logic [31:0] wdbus   [2];
  logic        as_s    [2];
  logic        rs_s    [2];
  logic        ws_s    [2];
  logic [3:0]  be      [2];
  logic [31:0] dbus    [2];
  logic        rdy     [2];
  logic        wt      [2];
  logic        ue      [2];
  logic        ce      [2];
  logic        brst    [2];
  logic        bclk    [2];
  logic        en      [2];
  logic [3:0]  wen     [2];
  logic [31:0] baddr   [2];
  logic [31:0] din     [2];
  logic [31:0] dout    [2];
  logic        corrupt [2];
  logic [31:0] din_q   [2];
  logic [31:0] mem     [2][256];

  int          m_idx;
  logic        m_wait;
  logic        m_rdy;
  logic [31:0] m_db;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  lmb_bram_if_ctrl #(.C_WAIT_STATES(0)) u_dut0 (
    .LMB_Clk(clk), .LMB_Rst(rst[0]), .LMB_ABus(abus[0]), .LMB_WriteDBus(wdbus[0]),
    .LMB_AddrStrobe(as_s[0]), .LMB_ReadStrobe(rs_s[0]), .LMB_WriteStrobe(ws_s[0]),
    .LMB_BE(be[0]), .Sl_DBus(dbus[0]), .Sl_Ready(rdy[0]), .Sl_Wait(wt[0]),
    .Sl_UE(ue[0]), .Sl_CE(ce[0]), .BRAM_Rst_A(brst[0]), .BRAM_Clk_A(bclk[0]),
    .BRAM_EN_A(en[0]), .BRAM_WEN_A(wen[0]), .BRAM_Addr_A(baddr[0]),
    .BRAM_Din_A(din[0]), .BRAM_Dout_A(dout[0])
  );

  lmb_bram_if_ctrl #(.C_WAIT_STATES(3)) u_dut1 (
    .LMB_Clk(clk), .LMB_Rst(rst[1]), .LMB_ABus(abus[1]), .LMB_WriteDBus(wdbus[1]),
    .LMB_AddrStrobe(as_s[1]), .LMB_ReadStrobe(rs_s[1]), .LMB_WriteStrobe(ws_s[1]),
    .LMB_BE(be[1]), .Sl_DBus(dbus[1]), .Sl_Ready(rdy[1]), .Sl_Wait(wt[1]),
    .Sl_UE(ue[1]), .Sl_CE(ce[1]), .BRAM_Rst_A(brst[1]), .BRAM_Clk_A(bclk[1]),
    .BRAM_EN_A(en[1]), .BRAM_WEN_A(wen[1]), .BRAM_Addr_A(baddr[1]),
    .BRAM_Din_A(din[1]), .BRAM_Dout_A(dout[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_bram
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) mem[g][i] <= '0;
      end else if (en[g]) begin
        din_q[g] <= mem[g][baddr[g][9:2]];
        for (int b = 0; b < 4; b++)
          if (wen[g][b]) mem[g][baddr[g][9:2]][8*b +: 8] <= dout[g][8*b +: 8];
      end
    end
    assign din[g] = corrupt[g] ? 32'hBAD0_BAD0 : din_q[g];
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Output monitor: each DUT has at most one access in flight, tracked in the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        m_idx = -1;
        for (int j = 0; j < sbq.size(); j++)
          if (m_idx < 0 && sbq[j].d == d) m_idx = j;
        m_wait = 1'b0;
        m_rdy  = 1'b0;
        m_db   = '0;
        if (m_idx >= 0) begin
          m_wait = (cyc > sbq[m_idx].start) && (cyc < sbq[m_idx].due);
          m_rdy  = (cyc == sbq[m_idx].due);
          m_db   = m_rdy ? sbq[m_idx].data : 32'h0;
        end
        chk($sformatf("sl_wait%0d", d), {31'b0, wt[d]}, {31'b0, m_wait});
        chk($sformatf("sl_ready%0d", d), {31'b0, rdy[d]}, {31'b0, m_rdy});
        chk($sformatf("sl_dbus%0d", d), dbus[d], m_db);
        if (m_idx >= 0 && cyc >= sbq[m_idx].due) sbq.delete(m_idx);
      end
    end
  end

  task automatic drive_idle(input int d);
    as_s[d] = 1'b0;
    rs_s[d] = 1'b0;
    ws_s[d] = 1'b0;
    be[d]   = 4'h0;
  endtask

  task automatic access(input vec_t v);
    @(posedge clk); #1;
    abus[v.d]  = v.addr;
    wdbus[v.d] = v.wdata;
    be[v.d]    = v.be;
    rs_s[v.d]  = v.rd;
    ws_s[v.d]  = v.wr;
    as_s[v.d]  = 1'b1;
    #1;
    chk("bram_en", {31'b0, en[v.d]}, {31'b0, v.exp_en});
    chk("bram_wen", {28'b0, wen[v.d]}, {28'b0, v.exp_wen});
    if (v.exp_en) sbq.push_back('{v.d, cyc, cyc + 1 + ws_of(v.d), v.exp_data});
    @(posedge clk); #1;
    drive_idle(v.d);
    repeat (ws_of(v.d) + 2) @(posedge clk);
  endtask

  vec_t vt [17];

  initial begin
    vt[0]  = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0};
    vt[1]  = '{0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'hDEAD_BEEF};
    vt[2]  = '{0, 32'h0000_0010, 32'h0000_00AA, 4'h1, 1'b0, 1'b1, 1'b1, 4'h1, 32'h0};
    vt[3]  = '{0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'hDEAD_BEAA};
    vt[4]  = '{0, 32'h0000_0014, 32'h55AA_55AA, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0};
    vt[5]  = '{0, 32'h0000_0014, 32'h1234_5678, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0};
    vt[6]  = '{0, 32'h0000_0014, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h55AA_55AA};
    vt[7]  = '{0, 32'h0000_0018, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0};
    vt[8]  = '{0, 32'h0000_0018, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'hCAFE_F00D};
    vt[9]  = '{0, 32'h0000_7FFC, 32'h0BAD_CAFE, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0};
    vt[10] = '{0, 32'h0000_7FFC, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0BAD_CAFE};
    vt[11] = '{0, 32'h0000_8000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    vt[12] = '{0, 32'hFFFF_FFFC, 32'h1111_1111, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0};
    vt[13] = '{1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hC, 1'b0, 1'b1, 1'b1, 4'hC, 32'h0};
    vt[14] = '{1, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'hA5A5_0000};
    vt[15] = '{1, 32'h0000_0024, 32'h1122_3344, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0};
    vt[16] = '{1, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0};

    mon_en  = 1'b0;
    mem_clr = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst[d]     = 1'b1;
      abus[d]    = '0;
      wdbus[d]   = '0;
      corrupt[d] = 1'b0;
      drive_idle(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, rdy[d]}, 32'h0);
      chk("rst_wait", {31'b0, wt[d]}, 32'h0);
      chk("rst_dbus", dbus[d], 32'h0);
      chk("rst_en", {31'b0, en[d]}, 32'h0);
      chk("rst_wen", {28'b0, wen[d]}, 32'h0);
      chk("rst_ue_ce", {30'b0, ue[d], ce[d]}, 32'h0);
      chk("rst_bram_rst", {31'b0, brst[d]}, 32'h1);
      chk("bram_clk", {31'b0, bclk[d]}, {31'b0, clk});
      rst[d] = 1'b0;
    end
    mem_clr = 1'b0;
    mon_en  = 1'b1;

    for (int i = 0; i < 17; i++) access(vt[i]);

    // Outside the window for 8 cycles: nothing may respond.
    @(posedge clk); #1;
    abus[0] = 32'h0000_8000;
    as_s[0] = 1'b1;
    rs_s[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("miss_en", {31'b0, en[0]}, 32'h0);
      @(posedge clk); #1;
    end
    drive_idle(0);

    // Wait-state read: data must be the value sampled one cycle after the strobe.
    @(posedge clk); #1;
    abus[1] = 32'h0000_0020;
    as_s[1] = 1'b1;
    rs_s[1] = 1'b1;
    sbq.push_back('{1, cyc, cyc + 4, 32'hA5A5_0000});
    @(posedge clk); #1;
    drive_idle(1);
    @(posedge clk); #1;
    corrupt[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    corrupt[1] = 1'b0;

    // Reset while in WAIT aborts the access without a Ready.
    @(posedge clk); #1;
    abus[1] = 32'h0000_0024;
    as_s[1] = 1'b1;
    rs_s[1] = 1'b1;
    sbq.push_back('{1, cyc, cyc + 4, 32'h1122_3344});
    @(posedge clk); #1;
    drive_idle(1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int j = sbq.size() - 1; j >= 0; j--)
      if (sbq[j].d == 1) sbq.delete(j);
    chk("abort_wait", {31'b0, wt[1]}, 32'h0);
    repeat (5) @(posedge clk);
    access('{1, 32'h0000_0024, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h1122_3344});

    // Back-to-back: fill 16 words, then read them with the strobe held through RESP.
    for (int i = 0; i < 16; i++)
      access('{0, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h0101), 4'hF,
               1'b0, 1'b1, 1'b1, 4'hF, 32'h0});
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      abus[0] = 32'h100 + 32'(4 * i);
      as_s[0] = 1'b1;
      rs_s[0] = 1'b1;
      #1;
      chk("b2b_en", {31'b0, en[0]}, 32'h1);
      sbq.push_back('{0, cyc, cyc + 1, 32'hC0DE_0000 + 32'(i * 32'h0101)});
      @(posedge clk); #2;
      chk("resp_hold_en", {31'b0, en[0]}, 32'h0);
    end
    @(posedge clk); #1;
    drive_idle(0);

    repeat (8) @(posedge clk);
    #1;
    chk("pending_responses", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
